// File: rtl/apb_bridge_mslv.sv
// AXI4-Lite slave to multi-slave APB3/APB4 master bridge.
// One outstanding transaction, window decode with DECERR, pready timeout, fair R/W arbitration.
`timescale 1ns/1ps
module apb_bridge_mslv #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NO_APB_SLAVES = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h0013_0000,
  parameter int                WIN_LOG2      = 12,
  parameter int                TIMEOUT       = 255,
  localparam int               STRB_W        = DATA_W / 8
) (
  input  logic                                   ACLKMST_ACLK,
  input  logic                                   ARSTMS_ACLK,
  input  logic                                   s_awvalid,
  output logic                                   s_awready,
  input  logic [ADDR_W-1:0]                      s_awaddr,
  input  logic [2:0]                             s_awprot,
  input  logic                                   s_wvalid,
  output logic                                   s_wready,
  input  logic [DATA_W-1:0]                      s_wdata,
  input  logic [STRB_W-1:0]                      s_wstrb,
  output logic                                   s_bvalid,
  input  logic                                   s_bready,
  output logic [1:0]                             s_bresp,
  input  logic                                   s_arvalid,
  output logic                                   s_arready,
  input  logic [ADDR_W-1:0]                      s_araddr,
  input  logic [2:0]                             s_arprot,
  output logic                                   s_rvalid,
  input  logic                                   s_rready,
  output logic [DATA_W-1:0]                      s_rdata,
  output logic [1:0]                             s_rresp,
  output logic [ADDR_W-1:0]                      apb_paddr_o,
  output logic [2:0]                             apb_pprot_o,
  output logic [NO_APB_SLAVES-1:0]               apb_pselx_o,
  output logic                                   apb_penable_o,
  output logic                                   apb_pwrite_o,
  output logic [DATA_W-1:0]                      apb_pwdata_o,
  output logic [STRB_W-1:0]                      apb_pstrb_o,
  input  logic [NO_APB_SLAVES-1:0]               apb_pready_i,
  input  logic [NO_APB_SLAVES-1:0][DATA_W-1:0]   apb_prdata_i,
  input  logic [NO_APB_SLAVES-1:0]               apb_pslverr_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  localparam int         IDX_W       = (NO_APB_SLAVES > 1) ? $clog2(NO_APB_SLAVES) : 1;
  localparam int         CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int         TO_LIM      = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_e                     state_q, state_d;
  logic                       rr_last_wr_q, rr_last_wr_d;
  logic [ADDR_W-1:0]          paddr_q, paddr_d;
  logic [2:0]                 pprot_q, pprot_d;
  logic [NO_APB_SLAVES-1:0]   psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [DATA_W-1:0]          pwdata_q, pwdata_d;
  logic [STRB_W-1:0]          pstrb_q, pstrb_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 resp_q, resp_d;
  logic [DATA_W-1:0]          rdata_q, rdata_d;
  logic                       bvalid_q, bvalid_d;
  logic                       rvalid_q, rvalid_d;

  logic                       wr_cand, rd_cand, grant_wr, grant_rd, done;
  logic [ADDR_W-1:0]          sel_addr, off, win;
  logic                       hit;

  assign wr_cand  = s_awvalid && s_wvalid;
  assign rd_cand  = s_arvalid;
  assign sel_addr = grant_wr ? s_awaddr : s_araddr;
  assign off      = sel_addr - BASE_ADDR;
  assign win      = off >> WIN_LOG2;
  // Lower bound checked explicitly so the subtraction cannot wrap into a window.
  assign hit      = (sel_addr >= BASE_ADDR) && (win < ADDR_W'(NO_APB_SLAVES));

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    rr_last_wr_d = rr_last_wr_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_wr = wr_cand && (!rd_cand || !rr_last_wr_q);
        grant_rd = rd_cand && !grant_wr;
        if (grant_wr || grant_rd) begin
          rr_last_wr_d = grant_wr;
          paddr_d      = sel_addr;
          pprot_d      = grant_wr ? s_awprot : s_arprot;
          pwrite_d     = grant_wr;
          pwdata_d     = grant_wr ? s_wdata : '0;
          pstrb_d      = grant_wr ? s_wstrb : '0;
          idx_d        = win[IDX_W-1:0];
          if (hit) begin
            psel_d                   = '0;
            psel_d[win[IDX_W-1:0]]   = 1'b1;
            state_d                  = S_SETUP;
          end else begin
            resp_d   = RESP_DECERR;
            rdata_d  = '0;
            bvalid_d = grant_wr;
            rvalid_d = grant_rd;
            state_d  = S_RESP;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (apb_pready_i[idx_q]) begin
          resp_d  = apb_pslverr_i[idx_q] ? RESP_SLVERR : RESP_OKAY;
          rdata_d = pwrite_q ? '0 : apb_prdata_i[idx_q];
          done    = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LIM))) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          done    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          psel_d    = '0;
          penable_d = 1'b0;
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if ((bvalid_q && s_bready) || (rvalid_q && s_rready)) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the reset clears every register.
  always_ff @(posedge ACLKMST_ACLK) begin
    if (ARSTMS_ACLK) begin
      state_q      <= S_IDLE;
      rr_last_wr_q <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_wr_q <= rr_last_wr_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign s_awready     = grant_wr && !ARSTMS_ACLK;
  assign s_wready      = grant_wr && !ARSTMS_ACLK;
  assign s_arready     = grant_rd && !ARSTMS_ACLK;
  assign s_bvalid      = bvalid_q;
  assign s_bresp       = bvalid_q ? resp_q : 2'b00;
  assign s_rvalid      = rvalid_q;
  assign s_rresp       = rvalid_q ? resp_q : 2'b00;
  assign s_rdata       = rvalid_q ? rdata_q : '0;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = pprot_q;
  assign apb_pselx_o   = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_apb_bridge_mslv.sv
// Self-checking bench for apb_bridge_mslv: scoreboard of expected AXI responses
// against a simple APB slave model with programmable wait, stuck and error behaviour.
`timescale 1ns/1ps
module tb_apb_bridge_mslv;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [N-1:0] psel, pready, pslverr;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic [N-1:0][31:0] prdata;

  apb_bridge_mslv #(
    .ADDR_W(32), .DATA_W(32), .NO_APB_SLAVES(N), .BASE_ADDR(32'h0013_0000),
    .WIN_LOG2(12), .TIMEOUT(4)
  ) dut (
    .ACLKMST_ACLK(clk), .ARSTMS_ACLK(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .apb_paddr_o(paddr), .apb_pprot_o(pprot), .apb_pselx_o(psel), .apb_penable_o(penable),
    .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb),
    .apb_pready_i(pready), .apb_prdata_i(prdata), .apb_pslverr_i(pslverr)
  );

  // APB slave model: pready rises after wait_n access cycles unless stuck.
  int acc_cnt = 0;
  int wait_n  = 0;
  bit stuck   = 1'b0;
  always @(posedge clk) begin
    if (penable && |psel) acc_cnt <= acc_cnt + 1;
    else                  acc_cnt <= 0;
  end
  assign pready = (!stuck && acc_cnt >= wait_n) ? {N{1'b1}} : {N{1'b0}};

  typedef struct packed {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rr_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [1:0] resp, input logic [31:0] rdata);
    exp_t e;
    e.wr = wr; e.resp = resp; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic drive_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_awvalid = 1'b1; s_awaddr = addr; s_awprot = 3'b010;
    s_wvalid  = 1'b1; s_wdata  = data; s_wstrb  = strb;
  endtask

  task automatic drive_r(input logic [31:0] addr);
    s_arvalid = 1'b1; s_araddr = addr; s_arprot = 3'b001;
  endtask

  // Returns 1 ns after the grant edge with the granted channel released.
  task automatic wait_grant(input bit wr);
    int n = 0;
    while (n < 50) begin
      #1;
      if (wr ? (s_awready && s_wready) : s_arready) break;
      @(negedge clk);
      n++;
    end
    check("grant_wait", 32'(n < 50), 1);
    check("grant_excl", 32'(wr ? s_arready : s_awready), 0);
    @(posedge clk);
    #1;
    if (wr) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
    else    s_arvalid = 1'b0;
    rr_model = wr;
  endtask

  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (wr) drive_w(addr, data, strb);
    else    drive_r(addr);
    wait_grant(wr);
  endtask

  task automatic collect();
    exp_t e;
    int n = 0;
    while (!(s_bvalid || s_rvalid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrives", 32'(n < 50), 1);
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("resp_is_write", 32'(s_bvalid), 32'(e.wr));
    check("resp_is_read", 32'(s_rvalid), 32'(!e.wr));
    if (e.wr) check("bresp", 32'(s_bresp), 32'(e.resp));
    else begin
      check("rresp", 32'(s_rresp), 32'(e.resp));
      check("rdata", s_rdata, e.rdata);
    end
    @(negedge clk);
    if (e.wr) check("bresp_held", 32'({s_bvalid, s_bresp}), 32'({1'b1, e.resp}));
    else      check("rresp_held", 32'({s_rvalid, s_rresp}), 32'({1'b1, e.resp}));
    if (e.wr) s_bready = 1'b1; else s_rready = 1'b1;
    @(posedge clk);
    #1;
    s_bready = 1'b0; s_rready = 1'b0;
    check("valid_dropped", 32'(s_bvalid | s_rvalid), 0);
    @(negedge clk);
  endtask

  initial begin
    bit exp_wr;
    bit seen;
    int pen;
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_awprot = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
    s_arvalid = 0; s_araddr = 0; s_arprot = 0; s_bready = 0; s_rready = 0;
    pslverr = '0;
    for (int k = 0; k < N; k++) prdata[k] = 32'hA000_0000 | 32'(k);

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({s_bvalid, s_rvalid, s_awready, s_arready, penable, pwrite}), 0);
    check("rst_psel", 32'(psel), 0);
    check("rst_paddr", paddr, 0);
    check("rst_rdata", s_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write, pready immediate: check SETUP/ACCESS/RESP latency.
    push(1'b1, 2'b00, 32'h0);
    req(1'b1, 32'h0013_1004, 32'hDEAD_BEEF, 4'hF);
    check("wr_setup_psel", 32'(psel), 32'h02);
    check("wr_setup_penable", 32'(penable), 0);
    check("wr_paddr", paddr, 32'h0013_1004);
    check("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    check("wr_pstrb", 32'(pstrb), 32'hF);
    check("wr_pwrite", 32'(pwrite), 1);
    @(posedge clk); #1;
    check("wr_access_penable", 32'({penable, psel}), 32'h102);
    check("wr_access_bvalid", 32'(s_bvalid), 0);
    @(posedge clk); #1;
    check("wr_t3_bvalid", 32'(s_bvalid), 1);
    check("wr_t3_psel", 32'({penable, psel}), 0);
    collect();

    // Read with three wait states on slave 2.
    wait_n = 3;
    prdata[2] = 32'h1234_5678;
    push(1'b0, 2'b00, 32'h1234_5678);
    req(1'b0, 32'h0013_2000, 32'h0, 4'h0);
    check("rd_psel", 32'(psel), 32'h04);
    check("rd_pwrite_pstrb", 32'({pwrite, pstrb}), 0);
    check("rd_pprot", 32'(pprot), 1);
    collect();
    wait_n = 0;

    // Decode misses: above the last window and below the base.
    push(1'b0, 2'b11, 32'h0);
    req(1'b0, 32'h0013_8000, 32'h0, 4'h0);
    check("dec_rd_psel", 32'(psel), 0);
    check("dec_rd_rvalid_t1", 32'(s_rvalid), 1);
    collect();
    push(1'b1, 2'b11, 32'h0);
    req(1'b1, 32'h0012_FFFC, 32'h1111_2222, 4'hF);
    check("dec_wr_psel", 32'(psel), 0);
    check("dec_wr_bvalid_t1", 32'(s_bvalid), 1);
    collect();

    // Last byte of the last window still decodes to slave 7.
    push(1'b1, 2'b00, 32'h0);
    req(1'b1, 32'h0013_7FFC, 32'h0BAD_F00D, 4'h5);
    check("top_win_psel", 32'(psel), 32'h80);
    collect();

    // AW without W must never be granted; a read gets through meanwhile.
    s_awvalid = 1'b1; s_awaddr = 32'h0013_5000; s_wvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      #1;
      if (s_awready || s_wready) seen = 1'b1;
      @(negedge clk);
    end
    check("aw_only_blocked", 32'(seen), 0);
    push(1'b0, 2'b00, 32'hA000_0006);
    req(1'b0, 32'h0013_6000, 32'h0, 4'h0);
    collect();
    #1;
    check("aw_only_after_rd", 32'(s_awready), 0);
    s_awvalid = 1'b0;
    @(negedge clk);

    // Simultaneous write and read requests, four rounds; slave 3 errors in round 1.
    for (int i = 0; i < 4; i++) begin
      pslverr = (i == 1) ? 8'h08 : 8'h00;
      drive_w(32'h0013_4010, 32'h0000_1000 + 32'(i), 4'hF);
      drive_r(32'h0013_3000);
      #1;
      exp_wr = !rr_model;
      check("arb_awready", 32'(s_awready), 32'(exp_wr));
      check("arb_arready", 32'(s_arready), 32'(!exp_wr));
      for (int j = 0; j < 2; j++) begin
        if (exp_wr) push(1'b1, 2'b00, 32'h0);
        else        push(1'b0, (i == 1) ? 2'b10 : 2'b00, 32'hA000_0003);
        wait_grant(exp_wr);
        collect();
        exp_wr = !exp_wr;
      end
    end
    pslverr = '0;

    // Stuck slave: timeout after exactly four access cycles.
    stuck = 1'b1;
    push(1'b0, 2'b10, 32'h0);
    req(1'b0, 32'h0013_3000, 32'h0, 4'h0);
    pen = 0;
    for (int n = 0; n < 30 && !s_rvalid; n++) begin
      if (penable) pen++;
      @(posedge clk); #1;
    end
    check("to_penable_cycles", pen, 4);
    check("to_psel_dropped", 32'(psel), 0);
    collect();

    // Reset in the middle of an access with rready low.
    req(1'b0, 32'h0013_3000, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("mid_access_penable", 32'(penable), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_psel", 32'(psel), 0);
    check("mid_rst_penable_rvalid", 32'({penable, s_rvalid}), 0);
    rst = 1'b0;
    stuck = 1'b0;
    rr_model = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (s_rvalid || s_bvalid || penable) seen = 1'b1;
    end
    check("mid_rst_no_resp", 32'(seen), 0);
    push(1'b0, 2'b00, 32'hA000_0001);
    req(1'b0, 32'h0013_1000, 32'h0, 4'h0);
    check("post_rst_psel", 32'(psel), 32'h02);
    collect();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
